// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush arbitration for the RV32IM 5-stage pipeline
// Optional performance counters are compiled in with `define STALL_PERF_COUNTERS_EN.
// Priority: data-memory freeze > branch redirect > load-use bubble > fetch wait,
// with a one-shot discard of the wrong-path fetch that returns after a redirect.

module pipeline_stall_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 LU_HAZ_SIG,
  input  logic                 BRANCH_TAKEN,
  input  logic                 INST_MEM_BUSY,
  input  logic                 DATA_MEM_BUSY,
  output logic                 PC_HOLD,
  output logic                 IF_ID_HOLD,
  output logic                 IF_ID_FLUSH,
  output logic                 ID_EX_HOLD,
  output logic                 ID_EX_BUBBLE,
  output logic                 EX_MEM_HOLD,
  output logic                 MEM_WB_BUBBLE,
  output logic [CNT_WIDTH-1:0] LU_BUBBLE_COUNT,
  output logic [CNT_WIDTH-1:0] DMEM_STALL_COUNT,
  output logic [CNT_WIDTH-1:0] FLUSH_COUNT
);

  typedef enum logic {
    RUN       = 1'b0,
    LU_BUBBLE = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   discard_q, discard_d;

  // Which priority level owns this cycle (reset excluded; it is handled separately)
  logic p1_dmem, p2_branch, p3_load_use;

  // Priority decode of the current cycle
  always_comb begin
    p1_dmem     = DATA_MEM_BUSY;
    p2_branch   = !DATA_MEM_BUSY && BRANCH_TAKEN;
    // The guard state masks a stale hazard level that the detector has not re-evaluated yet
    p3_load_use = !DATA_MEM_BUSY && !BRANCH_TAKEN && LU_HAZ_SIG && (state_q == RUN);
  end

  // Next-state and control outputs
  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    PC_HOLD       = 1'b0;
    IF_ID_HOLD    = 1'b0;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_HOLD    = 1'b0;
    ID_EX_BUBBLE  = 1'b0;
    EX_MEM_HOLD   = 1'b0;
    MEM_WB_BUBBLE = 1'b0;

    if (RESET) begin
      // Drain the pipeline with NOPs while held in reset
      state_d       = RUN;
      discard_d     = 1'b0;
      IF_ID_FLUSH   = 1'b1;
      ID_EX_BUBBLE  = 1'b1;
      MEM_WB_BUBBLE = 1'b1;
    end else if (p1_dmem) begin
      // Freeze everything up to MEM; branch/hazard stay visible because their stages are frozen
      PC_HOLD       = 1'b1;
      IF_ID_HOLD    = 1'b1;
      ID_EX_HOLD    = 1'b1;
      EX_MEM_HOLD   = 1'b1;
      MEM_WB_BUBBLE = 1'b1;
    end else begin
      if (p2_branch) begin
        // Squash the two wrong-path instructions; PC takes the target via the external mux
        IF_ID_FLUSH  = 1'b1;
        ID_EX_BUBBLE = 1'b1;
        state_d      = RUN;
        if (INST_MEM_BUSY) begin
          // The fetch in flight is wrong-path; drop it when it finally returns
          discard_d = 1'b1;
        end
      end else if (p3_load_use) begin
        PC_HOLD      = 1'b1;
        IF_ID_HOLD   = 1'b1;
        ID_EX_BUBBLE = 1'b1;
        state_d      = LU_BUBBLE;
      end else begin
        // Leaves the guard state after exactly one non-frozen cycle
        state_d = RUN;
      end

      if (INST_MEM_BUSY) begin
        // No valid fetch data: hold PC and, unless IF/ID is being held, feed a NOP
        PC_HOLD = 1'b1;
        if (!IF_ID_HOLD) begin
          IF_ID_FLUSH = 1'b1;
        end
      end

      // Returned wrong-path fetch is dropped; if IF/ID is held this cycle the drop is deferred
      if (discard_q && !INST_MEM_BUSY && !IF_ID_HOLD) begin
        IF_ID_FLUSH = 1'b1;
        discard_d   = 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= RUN;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

`ifdef STALL_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_WIDTH-1:0] dmem_cnt_q, dmem_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters; they stick at all-ones instead of wrapping
  always_comb begin
    lu_cnt_d    = lu_cnt_q;
    dmem_cnt_d  = dmem_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (p3_load_use && (lu_cnt_q != '1)) begin
      lu_cnt_d = lu_cnt_q + CNT_WIDTH'(1);
    end
    if (p1_dmem && (dmem_cnt_q != '1)) begin
      dmem_cnt_d = dmem_cnt_q + CNT_WIDTH'(1);
    end
    if (p2_branch && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Counter registers, cleared by reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lu_cnt_q    <= '0;
      dmem_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      lu_cnt_q    <= lu_cnt_d;
      dmem_cnt_q  <= dmem_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign LU_BUBBLE_COUNT  = lu_cnt_q;
  assign DMEM_STALL_COUNT = dmem_cnt_q;
  assign FLUSH_COUNT      = flush_cnt_q;
`else
  assign LU_BUBBLE_COUNT  = '0;
  assign DMEM_STALL_COUNT = '0;
  assign FLUSH_COUNT      = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed self-checking bench for pipeline_stall_controller

module tb_pipeline_stall_controller;

  localparam int CW = 4;
`ifdef STALL_PERF_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // Output vector order: {PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_BUBBLE, EX_MEM_HOLD, MEM_WB_BUBBLE}
  localparam logic [6:0] O_RST   = 7'b0010101;
  localparam logic [6:0] O_IDLE  = 7'b0000000;
  localparam logic [6:0] O_LU    = 7'b1100100;
  localparam logic [6:0] O_DMEM  = 7'b1101011;
  localparam logic [6:0] O_BR    = 7'b0010100;
  localparam logic [6:0] O_BR_IM = 7'b1010100;
  localparam logic [6:0] O_IM    = 7'b1010000;
  localparam logic [6:0] O_DISC  = 7'b0010000;

  logic          CLK = 1'b0;
  logic          RESET, LU_HAZ_SIG, BRANCH_TAKEN, INST_MEM_BUSY, DATA_MEM_BUSY;
  logic          PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_BUBBLE, EX_MEM_HOLD, MEM_WB_BUBBLE;
  logic [CW-1:0] LU_BUBBLE_COUNT, DMEM_STALL_COUNT, FLUSH_COUNT;
  logic [6:0]    outs;

  int n_cmp = 0;
  int n_bad = 0;

  pipeline_stall_controller #(.CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RESET(RESET), .LU_HAZ_SIG(LU_HAZ_SIG), .BRANCH_TAKEN(BRANCH_TAKEN),
    .INST_MEM_BUSY(INST_MEM_BUSY), .DATA_MEM_BUSY(DATA_MEM_BUSY),
    .PC_HOLD(PC_HOLD), .IF_ID_HOLD(IF_ID_HOLD), .IF_ID_FLUSH(IF_ID_FLUSH),
    .ID_EX_HOLD(ID_EX_HOLD), .ID_EX_BUBBLE(ID_EX_BUBBLE), .EX_MEM_HOLD(EX_MEM_HOLD),
    .MEM_WB_BUBBLE(MEM_WB_BUBBLE), .LU_BUBBLE_COUNT(LU_BUBBLE_COUNT),
    .DMEM_STALL_COUNT(DMEM_STALL_COUNT), .FLUSH_COUNT(FLUSH_COUNT)
  );

  always #5 CLK = ~CLK;

  assign outs = {PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_BUBBLE, EX_MEM_HOLD, MEM_WB_BUBBLE};

  function automatic logic [CW-1:0] exp_cnt(input int v);
    int s;
    s = (v > 15) ? 15 : v;
    return CNT_EN ? CW'(s) : '0;
  endfunction

  // Apply inputs mid-cycle; they settle well before the next rising edge
  task automatic drive(input logic rst, input logic lu, input logic br, input logic imb, input logic dmb);
    RESET = rst; LU_HAZ_SIG = lu; BRANCH_TAKEN = br; INST_MEM_BUSY = imb; DATA_MEM_BUSY = dmb;
    #3;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (outs !== O_RST) begin
        n_bad++;
        $display("FAIL reset_outs cyc%0d got=%b exp=%b", i, outs, O_RST);
      end
      tick();
    end
    n_cmp++;
    if ({LU_BUBBLE_COUNT, DMEM_STALL_COUNT, FLUSH_COUNT} !== '0) begin
      n_bad++;
      $display("FAIL reset_counters got=%h/%h/%h exp=0", LU_BUBBLE_COUNT, DMEM_STALL_COUNT, FLUSH_COUNT);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (outs !== O_IDLE) begin
      n_bad++;
      $display("FAIL reset_release got=%b exp=%b", outs, O_IDLE);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [6:0] exp_seq [4];
    exp_seq = '{O_LU, O_IDLE, O_LU, O_IDLE};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, (i < 3), 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (outs !== exp_seq[i]) begin
        n_bad++;
        $display("FAIL load_use cyc%0d got=%b exp=%b", i, outs, exp_seq[i]);
      end
      tick();
    end
    n_cmp++;
    if (LU_BUBBLE_COUNT !== exp_cnt(2)) begin
      n_bad++;
      $display("FAIL lu_count got=%0d exp=%0d", LU_BUBBLE_COUNT, exp_cnt(2));
    end
  endtask

  task automatic test_dmem_branch();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if (outs !== O_DMEM) begin
        n_bad++;
        $display("FAIL dmem_freeze cyc%0d got=%b exp=%b", i, outs, O_DMEM);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (outs !== O_BR) begin
      n_bad++;
      $display("FAIL branch_after_freeze got=%b exp=%b", outs, O_BR);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (DMEM_STALL_COUNT !== exp_cnt(4) || FLUSH_COUNT !== exp_cnt(1)) begin
      n_bad++;
      $display("FAIL dmem_flush_counts got=%0d/%0d exp=%0d/%0d",
               DMEM_STALL_COUNT, FLUSH_COUNT, exp_cnt(4), exp_cnt(1));
    end
    tick();
  endtask

  task automatic test_imem_discard();
    logic [6:0] exp_seq [5];
    logic       br_v  [5];
    logic       imb_v [5];
    exp_seq = '{O_BR_IM, O_IM, O_IM, O_DISC, O_IDLE};
    br_v    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    imb_v   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, br_v[i], imb_v[i], 1'b0);
      n_cmp++;
      if (outs !== exp_seq[i]) begin
        n_bad++;
        $display("FAIL imem_discard cyc%0d got=%b exp=%b", i, outs, exp_seq[i]);
      end
      tick();
    end
  endtask

  task automatic test_lu_imem();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (outs !== O_LU) begin
      n_bad++;
      $display("FAIL lu_with_imem_busy got=%b exp=%b", outs, O_LU);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp_seq [4];
    logic       dmb_v [4];
    exp_seq = '{O_LU, O_DMEM, O_IDLE, O_LU};
    dmb_v   = '{1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    // A freeze during the guard cycle must not consume the guard
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, dmb_v[i]);
      n_cmp++;
      if (outs !== exp_seq[i]) begin
        n_bad++;
        $display("FAIL guard_through_freeze cyc%0d got=%b exp=%b", i, outs, exp_seq[i]);
      end
      tick();
    end
    // Reset in the middle of a pending discard must clear it
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (outs !== O_RST) begin
      n_bad++;
      $display("FAIL reset_mid_discard got=%b exp=%b", outs, O_RST);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (outs !== O_IDLE) begin
      n_bad++;
      $display("FAIL discard_cleared got=%b exp=%b", outs, O_IDLE);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (outs !== O_LU) begin
        n_bad++;
        $display("FAIL sat_bubble ev%0d got=%b exp=%b", i, outs, O_LU);
      end
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if (LU_BUBBLE_COUNT !== exp_cnt(i + 1)) begin
        n_bad++;
        $display("FAIL sat_count ev%0d got=%0d exp=%0d", i, LU_BUBBLE_COUNT, exp_cnt(i + 1));
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_load_use();
    test_dmem_branch();
    test_imem_discard();
    test_lu_imem();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
